game_level_controller: RTL



---
 rtl/game_level_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/game_level_controller.sv
// Level sequencer for the binary encryption game: walks the player through the levels,
// tracks wrong guesses and drives the pass/fail/win indication on the red/green LEDs.
module game_level_controller #(
    parameter int NUM_LEVELS   = 3,
    parameter int MAX_ATTEMPTS = 3,
    parameter int SHOW_CYCLES  = 50000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic       verifier,
    output logic [1:0] level,
    output logic [2:0] attempts_left,
    output logic       level_load,
    output logic       ledr_out,
    output logic       ledg_out,
    output logic       game_won,
    output logic       game_over
);

    localparam int TMAX = (SHOW_CYCLES > BLINK_CYCLES) ? SHOW_CYCLES : BLINK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Loaded on entry, so a value of N-1 gives exactly N cycles in the state.
    localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_CYCLES - 1);
    localparam logic [1:0]    LAST_LEVEL = 2'(NUM_LEVELS);
    localparam logic [2:0]    ATT_RELOAD = 3'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        IDLE, LOAD, PLAY, SHOW_PASS, SHOW_FAIL, WON, LOST
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            level         <= 2'd1;
            attempts_left <= ATT_RELOAD;
            level_load    <= 1'b0;
            ledr_out      <= 1'b0;
            ledg_out      <= 1'b0;
            game_won      <= 1'b0;
            game_over     <= 1'b0;
            timer         <= '0;
        end else begin
            level_load <= 1'b0;
            case (state)
                IDLE, WON, LOST: begin
                    if (start) begin
                        state         <= LOAD;
                        level         <= 2'd1;
                        attempts_left <= ATT_RELOAD;
                        level_load    <= 1'b1;
                        ledr_out      <= 1'b0;
                        ledg_out      <= 1'b0;
                        game_won      <= 1'b0;
                        game_over     <= 1'b0;
                        timer         <= '0;
                    end else if (state == WON) begin
                        if (timer == '0) begin
                            ledg_out <= ~ledg_out;
                            timer    <= BLINK_LOAD;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state    <= PLAY;
                    ledr_out <= 1'b0;
                    ledg_out <= 1'b0;
                    timer    <= '0;
                end
                PLAY: begin
                    if (submit) begin
                        timer <= SHOW_LOAD;
                        if (verifier) begin
                            state    <= SHOW_PASS;
                            ledg_out <= 1'b1;
                        end else begin
                            state    <= SHOW_FAIL;
                            ledr_out <= 1'b1;
                            if (attempts_left != 3'd0)
                                attempts_left <= attempts_left - 3'd1;
                        end
                    end
                end
                SHOW_PASS: begin
                    if (timer == '0) begin
                        if (level == LAST_LEVEL) begin
                            state    <= WON;
                            game_won <= 1'b1;
                            ledg_out <= 1'b1;
                            timer    <= BLINK_LOAD;
                        end else begin
                            state         <= LOAD;
                            level         <= level + 2'd1;
                            attempts_left <= ATT_RELOAD;
                            level_load    <= 1'b1;
                            ledg_out      <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SHOW_FAIL: begin
                    if (timer == '0) begin
                        // Out of guesses: the red LED stays lit as the loss indication.
                        if (attempts_left == 3'd0) begin
                            state     <= LOST;
                            game_over <= 1'b1;
                        end else begin
                            state    <= PLAY;
                            ledr_out <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
